// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP-checked data-memory access stage.
//   - pmp_state_e  : access FSM states
//   - PERM_*       : bit positions inside a region's 4-bit permission field {L,W,R,EN}
//   - CAUSE_*      : RISC-V access-fault exception codes
//   - pmp_region_t : one protection region (base, limit, perm)
package pmp_pkg;

  localparam int PMP_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } pmp_state_e;

  localparam int PERM_EN = 0;
  localparam int PERM_R  = 1;
  localparam int PERM_W  = 2;
  localparam int PERM_L  = 3;

  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  typedef struct packed {
    logic [PMP_ADDR_W-1:0] base;
    logic [PMP_ADDR_W-1:0] limit;
    logic [3:0]            perm;
  } pmp_region_t;

endpackage

// File: rtl/pmp_checker.sv
// Combinational permission check for one access against the region table.
// Ports:
//   regions_i  : region table (index 0 has highest priority)
//   addr_i     : effective address of the access
//   is_store_i : 1 = store, 0 = load
//   priv_m_i   : 1 = machine mode, 0 = user mode
//   grant_o    : access allowed
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = PMP_ADDR_W
) (
  input  pmp_region_t       regions_i [NUM_REGIONS],
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              is_store_i,
  input  logic              priv_m_i,
  output logic              grant_o
);

  logic matched;

  always_comb begin
    // Default covers the no-match case: M-mode allowed, U-mode denied.
    grant_o = priv_m_i;
    matched = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      // base >= limit can never satisfy both bounds, so empty regions never match.
      if (!matched && regions_i[i].perm[PERM_EN] &&
          (addr_i >= regions_i[i].base) && (addr_i < regions_i[i].limit)) begin
        matched = 1'b1;
        if (priv_m_i && !regions_i[i].perm[PERM_L]) begin
          grant_o = 1'b1;
        end else begin
          grant_o = is_store_i ? regions_i[i].perm[PERM_W] : regions_i[i].perm[PERM_R];
        end
      end
    end
    // Word misalignment faults regardless of any permission.
    if (addr_i[1:0] != 2'b00) begin
      grant_o = 1'b0;
    end
  end

endmodule

// File: rtl/pmp_mem_access.sv
// PMP-checked data-memory access stage.
// Accepts a load/store from the control unit, checks it against the
// programmable protection regions, then either performs a req/ack transfer
// to data memory or raises a one-cycle access fault. Stalls the core while
// the access is in flight.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   mem_read, mem_write, addr, wdata : access request from the core
//   priv_m                           : 1 = machine mode
//   stall                            : freeze PC/regfile
//   rdata                            : load result (valid in DONE)
//   fault, fault_cause, fault_addr   : access-fault report
//   dmem_*                           : data-memory handshake
//   cfg_*                            : region programming port
module pmp_mem_access
  import pmp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGIONS = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              priv_m,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic [3:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [3:0]        cfg_perm
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  pmp_region_t       regions_q [NUM_REGIONS];
  pmp_region_t       regions_d [NUM_REGIONS];

  pmp_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              store_q;
  logic              priv_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q;
  logic [3:0]        cause_q;
  logic [ADDR_W-1:0] faddr_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0] dwdata_q;

  logic              access_req;
  logic              grant;

  assign access_req = mem_read | mem_write;

  // Region programming: locked regions and out-of-range indices are ignored.
  always_comb begin
    regions_d = regions_q;
    if (cfg_we) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if ((cfg_idx == 3'(i)) && !regions_q[i].perm[PERM_L]) begin
          regions_d[i].base  = cfg_base;
          regions_d[i].limit = cfg_limit;
          regions_d[i].perm  = cfg_perm;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        regions_q[i] <= '0;
      end
    end else begin
      regions_q <= regions_d;
    end
  end

  // The check sees the latched access and the region table as registered,
  // so a config write in the CHECK cycle only affects later accesses.
  pmp_checker #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W)
  ) u_checker (
    .regions_i  (regions_q),
    .addr_i     (addr_q),
    .is_store_i (store_q),
    .priv_m_i   (priv_q),
    .grant_o    (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      priv_q   <= 1'b0;
      tmo_q    <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      cause_q  <= '0;
      faddr_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_req) begin
            state_q <= ST_CHECK;
            addr_q  <= addr;
            wdata_q <= wdata;
            // Simultaneous read and write is handled as a store.
            store_q <= mem_write;
            priv_q  <= priv_m;
          end
        end
        ST_CHECK: begin
          if (grant) begin
            state_q  <= ST_REQ;
            req_q    <= 1'b1;
            we_q     <= store_q;
            daddr_q  <= addr_q;
            dwdata_q <= wdata_q;
            tmo_q    <= '0;
          end else begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
            cause_q <= store_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            faddr_q <= addr_q;
          end
        end
        ST_REQ: begin
          // tmo_q counts ack-less REQ cycles; an ack in the cycle where it
          // already equals TIMEOUT still wins over the bus fault.
          if (dmem_ack) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            if (!store_q) begin
              rdata_q <= dmem_rdata;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT)) begin
            state_q <= ST_FAULT;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fault_q <= 1'b1;
            cause_q <= store_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            faddr_q <= addr_q;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_FAULT: begin
          state_q <= ST_IDLE;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall is released in DONE/FAULT so the core retires in that cycle.
  assign stall = ((state_q == ST_IDLE) && access_req) ||
                 (state_q == ST_CHECK) || (state_q == ST_REQ);

  assign rdata       = rdata_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_addr  = faddr_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = daddr_q;
  assign dmem_wdata  = dwdata_q;

endmodule

// File: doc/pmp_mem_access.md
# pmp_mem_access

PMP-checked data-memory access stage sitting directly downstream of the control unit in the RISC-V datapath. Consumes `mem_read`/`mem_write`, the ALU-computed address and store data; checks the access against a small set of programmable protection regions; then either performs a handshaked transfer to data memory or raises a load/store access fault. Stalls the core for the duration of each access.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NUM_REGIONS`, 4, protection regions (1..8)
- `TIMEOUT`, 15, max cycles waiting for `dmem_ack` before bus fault
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_read`, `mem_write`  in  1  from control unit
- `addr`  in  ADDR_W  ALU result (effective address)
- `wdata`  in  DATA_W  store data (rs2)
- `priv_m`  in  1  1 = machine mode, 0 = user mode
- `stall`  out  1  freeze PC/regfile while high
- `rdata`  out  DATA_W  load result, valid in DONE
- `fault`  out  1  one-cycle access-fault pulse
- `fault_cause`  out  4  5 = load access fault, 7 = store access fault
- `fault_addr`  out  ADDR_W  faulting address, held until next fault
- `dmem_req`, `dmem_we`  out  1  memory request / write enable
- `dmem_addr`  out  ADDR_W, `dmem_wdata`  out  DATA_W
- `dmem_ack`  in  1, `dmem_rdata`  in  DATA_W
- `cfg_we`  in  1, `cfg_idx`  in  3, `cfg_base`/`cfg_limit`  in  ADDR_W, `cfg_perm`  in  4 ({L,W,R,EN})

## Operation
- Region i matches when EN=1 and `cfg_base <= addr < cfg_limit` (unsigned; base >= limit never matches). Lowest matching index wins.
- Matching region grants if R (load) or W (store) set. M-mode bypasses unlocked regions (always granted); locked (L=1) regions bind M-mode too. No match: M-mode granted, U-mode denied.
- `addr[1:0] != 0` is a fault regardless of permissions.
- Both `mem_read` and `mem_write` high: treated as store.
- Config write: `cfg_we` updates region `cfg_idx` on the clock edge; ignored if that region is locked or `cfg_idx >= NUM_REGIONS`. Lock clears only on reset.
- FSM: IDLE -> CHECK on `mem_read|mem_write` (latch addr, wdata, kind, priv). CHECK -> REQ if granted, else FAULT. REQ holds `dmem_req` with latched addr/data until `dmem_ack` -> DONE (capture `dmem_rdata` for loads); timeout counter reaching TIMEOUT -> FAULT. DONE -> IDLE, FAULT -> IDLE.
- `stall` = (IDLE and request) or CHECK or REQ. Low in DONE/FAULT so the core retires the instruction in that cycle.
- `fault` high only in FAULT; `fault_cause` per latched kind.

## Timing
- Reset: state IDLE, all outputs 0, all regions EN=0, L=0, base/limit 0, timeout counter 0. Reset mid-access drops `dmem_req` asynchronously; transfer abandoned.
- Latency with ack in first REQ cycle: stall high 3 cycles (IDLE, CHECK, REQ), DONE on cycle 4.
- `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_wdata` registered; stable throughout REQ; deasserted in the cycle after ack.
- Permission check uses region registers as they are at the CHECK edge; a `cfg_we` in the same cycle affects the next access only.
- Timeout counter resets on entering REQ; ack on the same cycle the counter hits TIMEOUT counts as success.
- No new request accepted in DONE/FAULT; core must present next instruction after stall release.

## Structure
- Package `pmp_pkg`: FSM state enum, perm bit indices (EN=0, R=1, W=2, L=3), fault cause constants, region record type.
- Sub-module `pmp_checker`: combinational priority match over region array, outputs `grant`.
- Top holds region registers, FSM, timeout counter, memory handshake.

## Test plan
- Region0 [0x1000,0x2000) perm R|EN, U-mode lw 0x1004, ack after 2 cycles -> dmem_req 2 cycles, rdata = dmem_rdata, stall 4 cycles, no fault.
- Same config, U-mode sw 0x1004 -> fault=1, cause=7, fault_addr=0x1004, dmem_req never asserted.
- M-mode lw 0x9000, no regions -> granted; then lock region0 covering 0x9000 with perm EN|L only -> M-mode lw 0x9000 faults cause=5.
- Locked region0, cfg_we to idx0 with new base -> region unchanged; unlocked idx1 write takes effect.
- Granted access, dmem_ack never -> fault after TIMEOUT cycles in REQ, cause per kind; rst_n low mid-REQ -> dmem_req 0 immediately, state IDLE.
- lw 0x1002 -> misaligned fault cause=5; overlapping regions 0 (R) and 1 (W) at same addr, sw -> region0 wins, fault.
